// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, divisor helper and FSM state types for the uart
package uart_pkg;

   localparam int DEF_CLK_FREQ = 50000000;
   localparam int DEF_BAUD     = 115200;
   localparam int DATA_BITS    = 8;
   localparam int OVERSAMPLE   = 16;

   function automatic int calc_div(input int clk_freq, input int rate);
      return clk_freq / rate;
   endfunction

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running rx oversample tick and restartable tx bit timer
module uart_baud_gen #(
   parameter int TX_DIV = 434,
   parameter int RX_DIV = 27
) (
   input  logic clk_50m,
   input  logic reset,
   input  logic tx_restart,
   output logic tx_tick,
   output logic rx_tick
);
   localparam int TXW = $clog2(TX_DIV);
   localparam int RXW = $clog2(RX_DIV);

   logic [TXW-1:0] tx_cnt;
   logic [RXW-1:0] rx_cnt;

   // tx_tick marks the last clock of a bit period
   assign tx_tick = (tx_cnt == TXW'(TX_DIV - 1));
   assign rx_tick = (rx_cnt == RXW'(RX_DIV - 1));

   always_ff @(posedge clk_50m or negedge reset) begin
      if (!reset) begin
         tx_cnt <= '0;
      end else if (tx_restart || tx_tick) begin
         tx_cnt <= '0;
      end else begin
         tx_cnt <= tx_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_50m or negedge reset) begin
      if (!reset) begin
         rx_cnt <= '0;
      end else if (rx_tick) begin
         rx_cnt <= '0;
      end else begin
         rx_cnt <= rx_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart.sv
// rtl/uart.sv - 8N1 uart with independent full-duplex tx and rx state machines
module uart
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = DEF_CLK_FREQ,
   parameter int BAUD     = DEF_BAUD
) (
   input  logic       clk_50m,
   input  logic       reset,
   input  logic [7:0] din,
   input  logic       wr_en,
   output logic       tx,
   output logic       tx_busy,
   input  logic       rx,
   output logic       rdy,
   input  logic       rdy_clr,
   output logic [7:0] dout
);
   localparam int TX_DIV = calc_div(CLK_FREQ, BAUD);
   localparam int RX_DIV = calc_div(CLK_FREQ, BAUD * OVERSAMPLE);

   logic                 tx_tick;
   logic                 rx_tick;
   logic                 tx_accept;
   tx_state_t            tx_state;
   logic [DATA_BITS-1:0] tx_shift;
   logic [2:0]           tx_bit;

   rx_state_t            rx_state;
   logic                 rx_meta;
   logic                 rx_sync;
   logic                 rx_hold;
   logic [3:0]           rx_tcnt;
   logic [2:0]           rx_bit;
   logic [DATA_BITS-1:0] rx_shift;

   assign tx_accept = (tx_state == TX_IDLE) && wr_en;

   uart_baud_gen #(
      .TX_DIV(TX_DIV),
      .RX_DIV(RX_DIV)
   ) u_baud_gen (
      .clk_50m   (clk_50m),
      .reset     (reset),
      .tx_restart(tx_accept),
      .tx_tick   (tx_tick),
      .rx_tick   (rx_tick)
   );

   always_ff @(posedge clk_50m or negedge reset) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
         tx_shift <= '0;
         tx_bit   <= '0;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         case (tx_state)
            TX_IDLE: if (wr_en) begin
               tx_shift <= din;
               tx_bit   <= '0;
               tx       <= 1'b0;
               tx_busy  <= 1'b1;
               tx_state <= TX_START;
            end
            TX_START: if (tx_tick) begin
               tx       <= tx_shift[0];
               tx_shift <= tx_shift >> 1;
               tx_state <= TX_DATA;
            end
            TX_DATA: if (tx_tick) begin
               if (tx_bit == 3'(DATA_BITS - 1)) begin
                  tx       <= 1'b1;
                  tx_state <= TX_STOP;
               end else begin
                  tx       <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                  tx_bit   <= tx_bit + 1'b1;
               end
            end
            TX_STOP: if (tx_tick) begin
               tx_busy  <= 1'b0;
               tx_state <= TX_IDLE;
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_50m or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   // After a framing error the line may still be low; rx_hold keeps IDLE
   // from treating that tail as a new start bit until the line goes high.
   always_ff @(posedge clk_50m or negedge reset) begin
      if (!reset) begin
         rx_state <= RX_IDLE;
         rx_hold  <= 1'b0;
         rx_tcnt  <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         dout     <= '0;
         rdy      <= 1'b0;
      end else begin
         if (rdy_clr) rdy <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_sync) begin
                  rx_hold <= 1'b0;
               end else if (!rx_hold) begin
                  rx_tcnt  <= '0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (rx_sync) begin
                  rx_state <= RX_IDLE;
               end else if (rx_tick) begin
                  if (rx_tcnt == 4'(OVERSAMPLE / 2 - 1)) begin
                     rx_tcnt  <= '0;
                     rx_bit   <= '0;
                     rx_state <= RX_DATA;
                  end else begin
                     rx_tcnt <= rx_tcnt + 1'b1;
                  end
               end
            end
            RX_DATA: if (rx_tick) begin
               if (rx_tcnt == 4'(OVERSAMPLE - 1)) begin
                  rx_tcnt  <= '0;
                  rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                  if (rx_bit == 3'(DATA_BITS - 1)) rx_state <= RX_STOP;
                  else                             rx_bit   <= rx_bit + 1'b1;
               end else begin
                  rx_tcnt <= rx_tcnt + 1'b1;
               end
            end
            RX_STOP: if (rx_tick) begin
               if (rx_tcnt == 4'(OVERSAMPLE - 1)) begin
                  rx_tcnt  <= '0;
                  rx_state <= RX_IDLE;
                  if (rx_sync) begin
                     dout <= rx_shift;
                     rdy  <= 1'b1;
                  end else begin
                     rx_hold <= 1'b1;
                  end
               end else begin
                  rx_tcnt <= rx_tcnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - directed self-checking bench for the uart
module tb_uart;
   localparam int TXD = 434;

   logic       clk_50m = 1'b0;
   logic       reset   = 1'b0;
   logic       wr_en   = 1'b0;
   logic       rdy_clr = 1'b0;
   logic       rx_drv  = 1'b1;
   logic       loop_en = 1'b0;
   logic [7:0] din     = 8'h00;
   logic       tx, tx_busy, rdy, rx_line;
   logic [7:0] dout;
   logic [9:0] tx_bits;
   logic [7:0] lb_bytes [3];
   int         checks = 0;
   int         errors = 0;
   int         bad;

   assign rx_line = loop_en ? tx : rx_drv;

   uart dut (
      .clk_50m(clk_50m),
      .reset  (reset),
      .din    (din),
      .wr_en  (wr_en),
      .tx     (tx),
      .tx_busy(tx_busy),
      .rx     (rx_line),
      .rdy    (rdy),
      .rdy_clr(rdy_clr),
      .dout   (dout)
   );

   always #10 clk_50m = ~clk_50m;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      logic [9:0] frame;
      frame = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv = frame[i];
         repeat (TXD) @(negedge clk_50m);
      end
      rx_drv = 1'b1;
   endtask

   task automatic wait_rdy(input string tag);
      int n;
      n = 0;
      while (!rdy && n < 6000) begin
         @(negedge clk_50m);
         n++;
      end
      check(tag, rdy, 1);
   endtask

   task automatic pulse_clr();
      rdy_clr = 1'b1;
      @(negedge clk_50m);
      rdy_clr = 1'b0;
   endtask

   // holds rdy_clr high through the cycle the next byte lands
   task automatic col_monitor();
      int  n;
      bit  seen_low;
      n = 0;
      seen_low = 0;
      rdy_clr = 1'b1;
      while (n < 6000) begin
         @(negedge clk_50m);
         n++;
         if (!rdy) seen_low = 1;
         else if (seen_low) break;
      end
      rdy_clr = 1'b0;
      check("col_rdy_set", rdy, 1);
      check("col_dout", dout, 8'h33);
      @(negedge clk_50m);
      check("col_rdy_hold", rdy, 1);
   endtask

   task automatic lb_send();
      int n;
      for (int i = 0; i < 3; i++) begin
         n = 0;
         while (tx_busy && n < 6000) begin
            @(negedge clk_50m);
            n++;
         end
         din   = lb_bytes[i];
         wr_en = 1'b1;
         @(negedge clk_50m);
         wr_en = 1'b0;
      end
   endtask

   task automatic lb_recv();
      for (int i = 0; i < 3; i++) begin
         wait_rdy($sformatf("lb_rdy%0d", i));
         check($sformatf("lb_busy%0d", i), tx_busy, 1);
         check($sformatf("lb_dout%0d", i), dout, lb_bytes[i]);
         pulse_clr();
         check($sformatf("lb_clr%0d", i), rdy, 0);
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tx_bits  = {1'b1, 8'hA5, 1'b0};
      lb_bytes = '{8'h00, 8'hFF, 8'h81};

      repeat (5) @(negedge clk_50m);
      check("rst_tx", tx, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_rdy", rdy, 0);
      check("rst_dout", dout, 8'h00);
      reset = 1'b1;
      repeat (5) @(negedge clk_50m);
      check("idle_tx", tx, 1);

      din   = 8'hA5;
      wr_en = 1'b1;
      @(negedge clk_50m);
      wr_en = 1'b0;
      for (int b = 0; b < 10; b++) begin
         bad = 0;
         for (int c = 0; c < TXD; c++) begin
            if (tx !== tx_bits[b] || tx_busy !== 1'b1) bad++;
            if (b == 2 && c == 100) begin
               din   = 8'hFF;
               wr_en = 1'b1;
            end else if (b == 2 && c == 101) begin
               wr_en = 1'b0;
            end else if (b == 9 && c == TXD - 1) begin
               wr_en = 1'b1;
            end
            @(negedge clk_50m);
         end
         check($sformatf("tx_bit%0d", b), bad, 0);
      end
      wr_en = 1'b0;
      check("tx_end_busy", tx_busy, 0);
      check("tx_end_line", tx, 1);
      repeat (3) @(negedge clk_50m);
      check("tx_fall_ignored", tx_busy, 0);

      din   = 8'h5A;
      wr_en = 1'b1;
      @(negedge clk_50m);
      wr_en = 1'b0;
      repeat (600) @(negedge clk_50m);
      check("midrst_pre_tx", tx, 0);
      reset = 1'b0;
      #1;
      check("midrst_tx", tx, 1);
      check("midrst_busy", tx_busy, 0);
      @(negedge clk_50m);
      reset = 1'b1;
      repeat (5) @(negedge clk_50m);

      send_rx(8'h3C, 1'b1);
      check("rx_rdy", rdy, 1);
      check("rx_dout", dout, 8'h3C);
      pulse_clr();
      check("rx_clr", rdy, 0);
      check("rx_clr_dout", dout, 8'h3C);

      rx_drv = 1'b0;
      repeat (100) @(negedge clk_50m);
      rx_drv = 1'b1;
      repeat (TXD * 12) @(negedge clk_50m);
      check("glitch_rdy", rdy, 0);
      check("glitch_dout", dout, 8'h3C);

      send_rx(8'h55, 1'b0);
      repeat (TXD * 12) @(negedge clk_50m);
      check("frame_rdy", rdy, 0);
      check("frame_dout", dout, 8'h3C);

      send_rx(8'h11, 1'b1);
      check("ovr1_dout", dout, 8'h11);
      send_rx(8'h22, 1'b1);
      repeat (20) @(negedge clk_50m);
      check("ovr_dout", dout, 8'h22);
      check("ovr_rdy", rdy, 1);

      fork
         send_rx(8'h33, 1'b1);
         col_monitor();
      join
      pulse_clr();
      repeat (5) @(negedge clk_50m);

      loop_en = 1'b1;
      repeat (5) @(negedge clk_50m);
      fork
         lb_send();
         lb_recv();
      join
      repeat (TXD * 2) @(negedge clk_50m);
      check("lb_done_busy", tx_busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart.md
Name: uart

Overview:
- Byte-wide 8N1 UART for the 50 MHz miner fabric.
- TX serialises one byte per wr_en pulse.
- RX deserialises bytes into dout with a sticky rdy flag that the consumer clears with rdy_clr.
- Sits under uart_core: it feeds received header bytes into the header shift register and carries the 4-byte nonce reply back out.

Parameters:
- CLK_FREQ, 50000000, clk_50m frequency in Hz.
- BAUD, 115200, line rate in bits per second.
- TX_DIV, CLK_FREQ/BAUD (integer division, 434), clocks per transmitted bit.
- RX_DIV, CLK_FREQ/(BAUD*16) (integer division, 27), clocks per RX oversample tick.

Ports:
- clk_50m  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low; low forces idle.
- din  input  8  byte to transmit.
- wr_en  input  1  single-cycle transmit request.
- tx  output  1  serial out; idles high.
- tx_busy  output  1  high while a frame is in progress.
- rx  input  1  serial in; asynchronous to clk_50m.
- rdy  output  1  sticky "byte received" flag.
- rdy_clr  input  1  clears rdy.
- dout  output  8  last good received byte.

Behaviour:
- Reset (async, reset=0): tx=1, tx_busy=0, rdy=0, dout=0, both FSMs idle, all counters 0. Applies immediately, including mid-frame; the frame is abandoned.
- TX FSM states: IDLE, START, DATA, STOP.
- TX in IDLE: wr_en=1 latches din and restarts the bit counter. Next cycle: state START, tx=0, tx_busy=1.
- TX timing: each bit is held exactly TX_DIV clocks. Order is start(0), d0..d7 LSB first, stop(1).
- TX frame end: after the stop bit's TX_DIV clocks, return to IDLE and drop tx_busy. Total busy time is 10*TX_DIV clocks.
- TX: wr_en while tx_busy=1 is ignored. wr_en on the same cycle tx_busy falls is also ignored; acceptance requires IDLE.
- RX input sync: rx passes through a 2-flop synchroniser, reset to 1.
- RX tick: one oversample tick every RX_DIV clocks, free-running.
- RX FSM states: IDLE, START, DATA, STOP.
- RX in IDLE: synchronised rx=0 moves to START and clears the sample counter.
- RX START: count 8 ticks. If rx is still 0 at the 8th tick, go to DATA (bit centre). If rx returns to 1 before then, it is a glitch; return to IDLE.
- RX DATA: sample every 16 ticks, shifting in LSB first, 8 bits.
- RX STOP: sample after 16 ticks.
  - Stop=1: dout gets the assembled byte and rdy is set to 1 the next cycle.
  - Stop=0 (framing error): byte discarded, dout and rdy unchanged.
  - Either way, return to IDLE.
- rdy handshake: rdy stays 1 until rdy_clr=1, which clears it the next cycle. rdy_clr while rdy=0 has no effect.
- Set and clear on the same cycle: set wins; rdy stays 1 and dout takes the new byte.
- Overrun: a new good byte while rdy=1 overwrites dout; rdy stays 1. There is no overrun flag.
- TX and RX are fully independent; simultaneous full-duplex operation is required.

Decomposition:
- Package uart_pkg holds:
  - default CLK_FREQ and BAUD;
  - divisor computation function;
  - TX and RX state enums;
  - DATA_BITS=8 and OVERSAMPLE=16.
- One sub-module, uart_baud_gen:
  - rx tick: free-running, every RX_DIV clocks;
  - tx bit counter: with a restart input driven on TX accept.
- TX and RX FSMs stay in the uart top.

Test Plan:
- Reset: hold reset=0, then release. Require tx=1, tx_busy=0, rdy=0, dout=8'h00. Reassert reset mid-TX-frame and require tx=1 and tx_busy=0 immediately.
- TX byte 8'hA5: pulse wr_en. Require tx low for 434 clocks, then bits 1,0,1,0,0,1,0,1 at 434 clocks each, then stop=1; tx_busy high for 4340 clocks. A second wr_en with 8'hFF mid-frame is ignored.
- RX byte 8'h3C driven at 115200 (434 clocks per bit). Require dout=8'h3C and rdy=1 within the stop-bit period. Pulse rdy_clr; require rdy=0 the next cycle and dout unchanged.
- Glitch and framing:
  - rx low for 100 clocks, then high: no reception, rdy stays 0.
  - Frame 8'h55 with stop bit=0: rdy stays 0 and dout is unchanged.
- Overrun and collision:
  - Receive 8'h11 and 8'h22 without clearing: dout=8'h22, rdy=1.
  - Assert rdy_clr on the exact cycle the next byte 8'h33 completes: rdy=1, dout=8'h33.
- Loopback: tx tied to rx, send 8'h00, 8'hFF, 8'h81 back-to-back, clearing rdy each time. Each byte arrives intact in order, and tx_busy and rdy toggle independently.
